// File: rtl/me_pkg.sv
// me_pkg: shared state type, width defaults and lane extraction for the MSAD selector
package me_pkg;
  typedef enum logic [1:0] {ACC, SKIP, OUT} state_t;
  localparam int ME_SAD_W = 14;
  localparam int ME_COORD_W = 5;
  localparam int MAX_VEC_W = 512;
  function automatic logic [31:0] lane_sad(input logic [MAX_VEC_W-1:0] v, input int k, input int w);
    return 32'(v >> (k * w));
  endfunction
endpackage

// File: rtl/me_sad_min_tree.sv
// me_sad_min_tree: combinational minimum over LANES SADs, lowest lane wins ties
module me_sad_min_tree
  import me_pkg::*;
#(
  parameter int SAD_W = ME_SAD_W,
  parameter int LANES = 4,
  parameter int IDX_W = 2
) (
  input  logic [LANES*SAD_W-1:0] sad,
  output logic [SAD_W-1:0]       min_sad,
  output logic [IDX_W-1:0]       min_idx
);
  logic [SAD_W-1:0] lv;
  // strict compare keeps the earliest lane on equal values
  always_comb begin
    lv = '0;
    min_sad = SAD_W'(lane_sad(MAX_VEC_W'(sad), 0, SAD_W));
    min_idx = '0;
    for (int k = 1; k < LANES; k++) begin
      lv = SAD_W'(lane_sad(MAX_VEC_W'(sad), k, SAD_W));
      if (lv < min_sad) begin
        min_sad = lv;
        min_idx = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/me_msad_select.sv
// me_msad_select: multi-lane minimum-SAD selector with early termination and result handshake
module me_msad_select
  import me_pkg::*;
#(
  parameter int SAD_W    = ME_SAD_W,
  parameter int COORD_W  = ME_COORD_W,
  parameter int LANES    = 4,
  parameter int SEARCH_W = 32,
  parameter int SEARCH_H = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   mode_i,
  input  logic [SAD_W-1:0]       thresh_i,
  input  logic                   sad_valid_i,
  output logic                   sad_ready_o,
  input  logic [LANES*SAD_W-1:0] sad_i,
  output logic [SAD_W-1:0]       MSAD,
  output logic [COORD_W-1:0]     MSAD_row,
  output logic [COORD_W-1:0]     MSAD_column,
  output logic                   early_o,
  output logic                   data_valid,
  input  logic                   res_ready_i
);
  localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(SEARCH_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(SEARCH_W - LANES);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(LANES);

  state_t             state;
  logic [COORD_W-1:0] row, col, best_row, best_col;
  logic [SAD_W-1:0]   best, thresh_l;
  logic               mode_l;
  logic [SAD_W-1:0]   t_min;
  logic [IDX_W-1:0]   t_idx;
  logic               acc, first, last, hit, take;
  logic [COORD_W-1:0] t_col, nxt_row, nxt_col;

  me_sad_min_tree #(.SAD_W(SAD_W), .LANES(LANES), .IDX_W(IDX_W)) u_tree (
    .sad(sad_i), .min_sad(t_min), .min_idx(t_idx)
  );

  assign sad_ready_o = state != OUT;

  // per-beat decisions: block start, block end, early hit and running-best update
  always_comb begin
    acc = sad_valid_i && sad_ready_o;
    first = state == ACC && row == '0 && col == '0;
    last = row == LAST_ROW && col == LAST_COL;
    hit = (first ? mode_i : mode_l) && t_min < (first ? thresh_i : thresh_l);
    take = first || t_min < best;
    t_col = col + COORD_W'(t_idx);
    nxt_col = col == LAST_COL ? '0 : col + STEP;
    nxt_row = last ? '0 : col == LAST_COL ? row + COORD_W'(1) : row;
  end

  // block state machine with registered result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC;
      row <= '0;
      col <= '0;
      best <= '1;
      best_row <= '0;
      best_col <= '0;
      mode_l <= 1'b0;
      thresh_l <= '0;
      MSAD <= '0;
      MSAD_row <= '0;
      MSAD_column <= '0;
      early_o <= 1'b0;
      data_valid <= 1'b0;
    end else if (clear_i) begin
      state <= ACC;
      row <= '0;
      col <= '0;
      best <= '1;
      best_row <= '0;
      best_col <= '0;
      mode_l <= 1'b0;
      thresh_l <= '0;
      MSAD <= '0;
      MSAD_row <= '0;
      MSAD_column <= '0;
      early_o <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        ACC: if (acc) begin
          if (first) begin
            mode_l <= mode_i;
            thresh_l <= thresh_i;
          end
          if (hit || last) begin
            MSAD <= hit || take ? t_min : best;
            MSAD_row <= hit || take ? row : best_row;
            MSAD_column <= hit || take ? t_col : best_col;
            early_o <= hit;
            data_valid <= 1'b1;
            best <= '1;
            state <= last ? OUT : SKIP;
          end else if (take) begin
            best <= t_min;
            best_row <= row;
            best_col <= t_col;
          end
          row <= nxt_row;
          col <= nxt_col;
        end
        SKIP: begin
          if (data_valid && res_ready_i) data_valid <= 1'b0;
          if (acc) begin
            row <= nxt_row;
            col <= nxt_col;
            if (last) state <= data_valid && !res_ready_i ? OUT : ACC;
          end
        end
        OUT: if (data_valid && res_ready_i) begin
          data_valid <= 1'b0;
          row <= '0;
          col <= '0;
          best <= '1;
          state <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_me_msad_select.sv
// tb_me_msad_select: randomized and directed check of the MSAD selector against a raster-scan model
module tb_me_msad_select;
  localparam int SW = 14, CW = 5, L = 4, W = 8, H = 2, N = W * H, NB = N / L;

  logic          clk = 0, rst = 0, clear_i = 0, mode_i = 0, sad_valid_i = 0, res_ready_i = 0;
  logic [SW-1:0] thresh_i = '0;
  logic [L*SW-1:0] sad_i = '0;
  logic          sad_ready_o, early_o, data_valid;
  logic [SW-1:0] MSAD;
  logic [CW-1:0] MSAD_row, MSAD_column;

  int n_tests = 0, n_fail = 0;
  logic [SW-1:0] cand [N];
  int e_sad, e_row, e_col, e_early, e_dec;

  me_msad_select #(.SAD_W(SW), .COORD_W(CW), .LANES(L), .SEARCH_W(W), .SEARCH_H(H)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mode_i(mode_i), .thresh_i(thresh_i),
    .sad_valid_i(sad_valid_i), .sad_ready_o(sad_ready_o), .sad_i(sad_i),
    .MSAD(MSAD), .MSAD_row(MSAD_row), .MSAD_column(MSAD_column),
    .early_o(early_o), .data_valid(data_valid), .res_ready_i(res_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // expected result: first beat whose minimum beats the threshold, else raster-first global minimum
  task automatic model(input int mode, input int thr);
    int m, mi;
    e_early = 0;
    e_dec = NB - 1;
    if (mode != 0)
      for (int b = 0; b < NB; b++) begin
        if (e_early == 0) begin
          m = cand[b*L];
          mi = b * L;
          for (int l = 1; l < L; l++)
            if (cand[b*L+l] < m) begin
              m = cand[b*L+l];
              mi = b * L + l;
            end
          if (m < thr) begin
            e_early = 1;
            e_dec = b;
            e_sad = m;
            e_row = mi / W;
            e_col = mi % W;
          end
        end
      end
    if (e_early == 0) begin
      m = cand[0];
      mi = 0;
      for (int i = 1; i < N; i++)
        if (cand[i] < m) begin
          m = cand[i];
          mi = i;
        end
      e_sad = m;
      e_row = mi / W;
      e_col = mi % W;
    end
  endtask

  task automatic beat(input int b);
    sad_valid_i = 1;
    for (int l = 0; l < L; l++) sad_i[l*SW +: SW] = cand[b*L+l];
    @(posedge clk);
    #1;
    sad_valid_i = 0;
  endtask

  task automatic run_block(input int mode, input int thr, input int hold, input bit ack_skip);
    bit acked = 0;
    model(mode, thr);
    for (int b = 0; b < NB; b++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      mode_i = b == 0 ? mode[0] : 1'($urandom_range(0, 1));
      thresh_i = b == 0 ? SW'(thr) : SW'($urandom_range(0, 40));
      chk("beat_ready", sad_ready_o, 1);
      beat(b);
      if (b < e_dec) chk("dv_before", data_valid, 0);
      else if (b == e_dec) begin
        chk("dv", data_valid, 1);
        chk("msad", MSAD, e_sad);
        chk("row", MSAD_row, e_row);
        chk("col", MSAD_column, e_col);
        chk("early", early_o, e_early);
      end else chk("skip_dv", data_valid, acked ? 0 : 1);
      if (b == e_dec && e_early != 0 && b < NB - 1 && ack_skip) begin
        res_ready_i = 1;
        @(posedge clk);
        #1;
        res_ready_i = 0;
        chk("skip_ack_dv", data_valid, 0);
        acked = 1;
      end
    end
    if (acked) begin
      chk("post_skip_ready", sad_ready_o, 1);
      chk("post_skip_dv", data_valid, 0);
    end else begin
      repeat (hold) begin
        sad_valid_i = 1;
        sad_i = (L*SW)'({$urandom, $urandom});
        chk("hold_ready", sad_ready_o, 0);
        chk("hold_dv", data_valid, 1);
        chk("hold_msad", MSAD, e_sad);
        chk("hold_row", MSAD_row, e_row);
        chk("hold_col", MSAD_column, e_col);
        @(posedge clk);
        #1;
      end
      sad_valid_i = 0;
      res_ready_i = 1;
      chk("rel_dv_pre", data_valid, 1);
      @(posedge clk);
      #1;
      res_ready_i = 0;
      chk("rel_dv", data_valid, 0);
      chk("rel_ready", sad_ready_o, 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", data_valid, 0);
    chk("rst_ready", sad_ready_o, 1);
    chk("rst_msad", MSAD, 0);
    chk("rst_early", early_o, 0);
    rst = 1;
    @(posedge clk);
    #1;

    foreach (cand[i]) cand[i] = 100;
    cand[10] = 7;
    run_block(0, 0, 5, 0);

    foreach (cand[i]) cand[i] = 50;
    cand[1] = 5;
    cand[14] = 5;
    run_block(0, 0, 1, 0);

    foreach (cand[i]) cand[i] = 30;
    cand[0] = 9;
    cand[3] = 9;
    run_block(0, 0, 0, 0);

    foreach (cand[i]) cand[i] = 20;
    cand[5] = 3;
    run_block(1, 10, 2, 0);
    run_block(1, 10, 0, 1);

    foreach (cand[i]) cand[i] = '1;
    run_block(1, 16383, 1, 0);

    foreach (cand[i]) cand[i] = 1;
    mode_i = 0;
    beat(0);
    beat(1);
    clear_i = 1;
    @(posedge clk);
    #1;
    clear_i = 0;
    chk("clr_dv", data_valid, 0);
    chk("clr_ready", sad_ready_o, 1);
    chk("clr_msad", MSAD, 0);
    foreach (cand[i]) cand[i] = 40;
    cand[9] = 12;
    run_block(0, 0, 1, 0);

    foreach (cand[i]) cand[i] = SW'($urandom_range(0, 63));
    mode_i = 0;
    for (int b = 0; b < NB; b++) beat(b);
    chk("pre_rst_dv", data_valid, 1);
    #2 rst = 0;
    #1;
    chk("arst_dv", data_valid, 0);
    chk("arst_ready", sad_ready_o, 1);
    chk("arst_msad", MSAD, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;

    repeat (40) begin
      foreach (cand[i]) cand[i] = ($urandom_range(0, 9) == 0) ? '1 : SW'($urandom_range(0, 63));
      run_block($urandom_range(0, 1), $urandom_range(0, 20), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
